// File: rtl/frame_sched_pkg.sv
// Shared types and widths for the frame scheduler slice.
package frame_sched_pkg;

  localparam int unsigned X_W   = 8;
  localparam int unsigned Y_W   = 7;
  localparam int unsigned COL_W = 3;

  // 60 ms at 50 MHz.
  localparam int unsigned TICK_CYCLES_DEFAULT = 3000000;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StTick,
    StBird,
    StPipes
  } state_e;

endpackage

// File: rtl/frame_scheduler_if.sv
// Renderer handshakes plus the single VGA pixel-write port.
// master: the scheduler side; slave: renderers and VGA adapter.
interface frame_scheduler_if;
  import frame_sched_pkg::*;

  logic             bird_gnt;
  logic             bird_valid;
  logic             bird_last;
  logic [X_W-1:0]   bird_x;
  logic [Y_W-1:0]   bird_y;
  logic [COL_W-1:0] bird_colour;

  logic             pipe_gnt;
  logic             pipe_valid;
  logic             pipe_last;
  logic [X_W-1:0]   pipe_x;
  logic [Y_W-1:0]   pipe_y;
  logic [COL_W-1:0] pipe_colour;

  logic [X_W-1:0]   x;
  logic [Y_W-1:0]   y;
  logic [COL_W-1:0] colour;
  logic             plot;

  modport master (
    output bird_gnt, pipe_gnt, x, y, colour, plot,
    input  bird_valid, bird_last, bird_x, bird_y, bird_colour,
    input  pipe_valid, pipe_last, pipe_x, pipe_y, pipe_colour
  );

  modport slave (
    input  bird_gnt, pipe_gnt, x, y, colour, plot,
    output bird_valid, bird_last, bird_x, bird_y, bird_colour,
    output pipe_valid, pipe_last, pipe_x, pipe_y, pipe_colour
  );

endinterface

// File: rtl/frame_scheduler_tick_timer.sv
// Game-tick period counter. expire is registered, so it is high in the cycle
// after cnt is seen at zero; the counter reloads on that same edge.
module tick_timer #(
  parameter int unsigned TICK_CYCLES = 3000000
) (
  input  logic clk,
  input  logic resetn,
  input  logic run,
  output logic expire
);

  localparam int unsigned CntW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CntW-1:0] Reload = CntW'(TICK_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            expire_q, expire_d;

  // Count down while running; run=0 parks the counter at its reload value.
  always_comb begin
    cnt_d    = cnt_q;
    expire_d = 1'b0;
    if (!run) begin
      cnt_d = Reload;
    end else if (cnt_q == '0) begin
      cnt_d    = Reload;
      expire_d = 1'b1;
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter and expire pulse registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q    <= Reload;
      expire_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      expire_q <= expire_d;
    end
  end

  assign expire = expire_q;

endmodule

// File: rtl/frame_scheduler.sv
// Frame sequencer: tick, then bird pass, then pipe pass, on one pixel port.
// Late ticks are remembered in pending and counted in overrun.
module frame_scheduler import frame_sched_pkg::*; #(
  parameter int unsigned TICK_CYCLES = TICK_CYCLES_DEFAULT,
  parameter int unsigned OVR_W       = 8
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               run,
  output logic               tick,
  frame_scheduler_if.master  bus,
  output logic [15:0]        frame_count,
  output logic [OVR_W-1:0]   overrun
);

  state_e           state_q, state_d;
  logic             pending_q, pending_d;
  logic [15:0]      frame_count_q, frame_count_d;
  logic [OVR_W-1:0] overrun_q, overrun_d;
  logic             ovr_inc;
  logic             expire;
  logic             bird_beat, pipe_beat;

  logic             plot_q, plot_d;
  logic [X_W-1:0]   x_q, x_d;
  logic [Y_W-1:0]   y_q, y_d;
  logic [COL_W-1:0] colour_q, colour_d;

  tick_timer #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_tick_timer (
    .clk   (clk),
    .resetn(resetn),
    .run   (run),
    .expire(expire)
  );

  assign tick         = (state_q == StTick);
  assign bus.bird_gnt = (state_q == StBird);
  assign bus.pipe_gnt = (state_q == StPipes);

  // Only a granted requester's valid counts as a beat.
  assign bird_beat = bus.bird_gnt & bus.bird_valid;
  assign pipe_beat = bus.pipe_gnt & bus.pipe_valid;

  // Next state, pending flag and frame/overrun counters.
  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    frame_count_d = frame_count_q;
    overrun_d     = overrun_q;
    ovr_inc       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (run) state_d = StWait;
      end
      StWait: begin
        // A coincident expire and pending is one late tick, not two ticks.
        if (pending_q || expire) begin
          state_d = StTick;
          ovr_inc = pending_q & expire;
        end
      end
      StTick: begin
        pending_d = expire;
        state_d   = StBird;
      end
      StBird: begin
        if (expire) begin
          pending_d = 1'b1;
          ovr_inc   = pending_q;
        end
        if (bird_beat && bus.bird_last) state_d = StPipes;
      end
      StPipes: begin
        if (expire) begin
          pending_d = 1'b1;
          ovr_inc   = pending_q;
        end
        if (pipe_beat && bus.pipe_last) begin
          state_d       = StWait;
          frame_count_d = frame_count_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (ovr_inc && (overrun_q != '1)) overrun_d = overrun_q + 1'b1;
    // Dropping run abandons the frame without counting it.
    if (!run) begin
      state_d       = StIdle;
      pending_d     = 1'b0;
      frame_count_d = frame_count_q;
      overrun_d     = overrun_q;
    end
  end

  // Pixel port: load from whichever source has a granted valid beat.
  always_comb begin
    plot_d   = bird_beat | pipe_beat;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    if (bird_beat) begin
      x_d      = bus.bird_x;
      y_d      = bus.bird_y;
      colour_d = bus.bird_colour;
    end else if (pipe_beat) begin
      x_d      = bus.pipe_x;
      y_d      = bus.pipe_y;
      colour_d = bus.pipe_colour;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= StIdle;
      pending_q     <= 1'b0;
      frame_count_q <= '0;
      overrun_q     <= '0;
      plot_q        <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      colour_q      <= '0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      frame_count_q <= frame_count_d;
      overrun_q     <= overrun_d;
      plot_q        <= plot_d;
      x_q           <= x_d;
      y_q           <= y_d;
      colour_q      <= colour_d;
    end
  end

  assign bus.plot   = plot_q;
  assign bus.x      = x_q;
  assign bus.y      = y_q;
  assign bus.colour = colour_q;
  assign frame_count = frame_count_q;
  assign overrun     = overrun_q;

endmodule

// File: doc/frame_scheduler.md
# frame_scheduler

Frame-level sequencer for the game. It sits between the game controller, the game datapath, and the VGA adapter's single pixel-write port. It generates the game tick that advances the datapath, then grants the write port first to the bird renderer and then to the pipe renderer, once per frame. It also flags frames whose rendering overran the tick period.

## Interface
- TICK_CYCLES, 3000000: clock cycles per game tick (3000000 cycles = 60 ms at 50 MHz).
- OVR_W, 8: width of the saturating overrun counter.
- clk  in  1  system clock.
- resetn  in  1  reset; synchronous, active-low.
- run  in  1  high while the game is in its move state; low forces idle.
- tick  out  1  one-cycle pulse; the datapath advances one step.
- bird_gnt  out  1  write port granted to the bird renderer.
- bird_valid, bird_last  in  1 each  pixel valid / final pixel of the bird pass.
- bird_x  in  8, bird_y  in  7, bird_colour  in  3  bird pixel.
- pipe_gnt  out  1; pipe_valid, pipe_last  in  1 each; pipe_x  in  8, pipe_y  in  7, pipe_colour  in  3  same signal set for the pipe renderer.
- x  out  8, y  out  7, colour  out  3, plot  out  1  registered VGA write port.
- frame_count  out  16  completed frames; wraps.
- overrun  out  OVR_W  late ticks; saturates at all-ones.

## Operation
- States: IDLE, WAIT, TICK, BIRD, PIPES.
- IDLE: if run=1, go to WAIT.
- WAIT: if pending=1 or expire=1, go to TICK.
- TICK: tick=1 for exactly one cycle, pending is cleared, then go to BIRD.
- BIRD: bird_gnt=1. When bird_valid & bird_last is sampled, go to PIPES.
- PIPES: pipe_gnt=1. When pipe_valid & pipe_last is sampled, go to WAIT and increment frame_count.
- Tick timer (sub-module):
  - cnt resets to TICK_CYCLES-1.
  - It decrements on every cycle with run=1, in any state.
  - When cnt=0 and run=1, it asserts expire for one cycle and reloads TICK_CYCLES-1.
- Pending and overrun:
  - expire in BIRD, PIPES or TICK sets pending.
  - expire while pending is already 1 increments overrun (saturating); pending stays 1.
  - An expire arriving in WAIT at the same time as pending is the same event: it increments overrun and the state still goes to TICK once.
- Exactly one of bird_gnt and pipe_gnt may be high at a time. Both are low in IDLE, WAIT and TICK.
- Write port:
  - Each cycle, plot <= (bird_gnt & bird_valid) | (pipe_gnt & pipe_valid).
  - x, y and colour are loaded from the granted source only when that source is valid; otherwise they hold their value.
- A valid from a requester without a grant is ignored. There is no backpressure: every granted valid pixel is written.
- run=0, in any state:
  - Next state is IDLE; grants drop the next cycle.
  - cnt reloads to TICK_CYCLES-1 and pending clears.
  - frame_count and overrun hold their values.
  - A frame in progress is abandoned; it is not counted.
- Arithmetic: frame_count wraps from 0xFFFF to 0. overrun sticks at 2^OVR_W-1.

## Timing
- Reset values:
  - state IDLE; pending 0; cnt TICK_CYCLES-1.
  - tick, bird_gnt, pipe_gnt, plot, x, y, colour, frame_count, overrun all 0.
  - Reset mid-frame behaves the same as power-up.
- First tick: if run rises in cycle 0, expire occurs in cycle TICK_CYCLES-1 and tick is high in cycle TICK_CYCLES+1.
- Later ticks are spaced exactly TICK_CYCLES cycles apart, provided rendering finishes before expire.
- Grant latency:
  - bird_gnt rises the cycle after tick.
  - pipe_gnt rises the cycle after the bird_last beat; there is no gap cycle in which both grants are low.
  - After the pipe_last beat, both grants are low from the next cycle.
- Write-port latency: pixel in cycle n appears on x/y/colour/plot in cycle n+1.
- A last beat is also a valid pixel and is written.

## Structure
- Package frame_sched_pkg holds:
  - the state enum;
  - the widths X_W=8, Y_W=7, COL_W=3;
  - the default TICK_CYCLES.
- Sub-module tick_timer (run, expire, reload on run=0). Everything else stays in frame_scheduler.

## Test plan
All scenarios use TICK_CYCLES=8, OVR_W=8.
- Basic frame: run=1 from cycle 0; bird sends 2 pixels, pipe sends 3 pixels, each ending with last. Required:
  - tick at cycle 9;
  - 5 plot pulses, each one cycle after its input beat;
  - frame_count=1;
  - next tick at cycle 17.
- Overrun: the bird withholds last for 20 cycles. Required:
  - overrun=1;
  - exactly one TICK after PIPES completes;
  - no tick pulses while BIRD is active.
- Stray valid: pipe_valid=1 with pipe_x=0x55 during BIRD -> plot stays 0 for those beats and x never takes 0x55.
- Abort: run drops during PIPES. Required:
  - pipe_gnt low the next cycle;
  - frame_count unchanged;
  - after run re-asserts, first tick arrives TICK_CYCLES+1 cycles later.
- Reset mid-BIRD: resetn=0 for one cycle -> every output 0, state IDLE on the following cycle.
- Saturation: force 300 overruns -> overrun=0xFF.
